// File: rtl/wtm8_mul16_sequencer.sv
// wtm8_mul16_sequencer: 16x16 unsigned multiplier stepping one shared 8x8 Wallace-tree multiplier over four cycles.
// Optional feature macro BYPASS_ZERO_EN: zero operands skip straight to DONE with a zero product.
module wtm8 (
  input  logic [7:0]  a_i,
  input  logic [7:0]  b_i,
  output logic [15:0] p_o
);
  function automatic logic [31:0] csa(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
    return {((x & y) | (x & z) | (y & z)) << 1, x ^ y ^ z};
  endfunction
  logic [15:0] pp [8];
  logic [15:0] s0, c0, s1, c1, s2, c2, s3, c3, s4, c4, s5, c5;
  for (genvar i = 0; i < 8; i++) begin : g_pp
    assign pp[i] = b_i[i] ? (16'(a_i) << i) : '0;
  end
  // Eight rows reduce 8 -> 6 -> 4 -> 3 -> 2 before the final carry-propagate add.
  assign {c0, s0} = csa(pp[0], pp[1], pp[2]);
  assign {c1, s1} = csa(pp[3], pp[4], pp[5]);
  assign {c2, s2} = csa(s0, c0, s1);
  assign {c3, s3} = csa(c1, pp[6], pp[7]);
  assign {c4, s4} = csa(s2, c2, s3);
  assign {c5, s5} = csa(s4, c4, c3);
  assign p_o = s5 + c5;
endmodule

module wtm8_mul16_sequencer #(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_a,
  input  logic [15:0]      in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_product,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);
  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
  state_t           state_q, state_d;
  logic [1:0]       step_q, step_d;
  logic [31:0]      acc_q, acc_d, prod_q, prod_d, sum;
  logic [15:0]      a_q, a_d, b_q, b_d, pp;
  logic [TAG_W-1:0] tag_q, tag_d, otag_q, otag_d;
  logic [4:0]       sh;
  // step[1] picks the high byte of a, step[0] the high byte of b.
  wtm8 u_wtm8 (
    .a_i(step_q[1] ? a_q[15:8] : a_q[7:0]),
    .b_i(step_q[0] ? b_q[15:8] : b_q[7:0]),
    .p_o(pp)
  );
  assign sh          = step_q == 2'd0 ? 5'd0 : step_q == 2'd3 ? 5'd16 : 5'd8;
  assign sum         = acc_q + (32'(pp) << sh);
  assign in_ready    = state_q == IDLE && !rst;
  assign out_valid   = state_q == DONE;
  assign busy        = state_q != IDLE;
  assign out_product = prod_q;
  assign out_tag     = otag_q;
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    acc_d   = acc_q;
    a_d     = a_q;
    b_d     = b_q;
    tag_d   = tag_q;
    prod_d  = prod_q;
    otag_d  = otag_q;
    case (state_q)
      IDLE: if (in_valid && in_ready) begin
        a_d     = in_a;
        b_d     = in_b;
        tag_d   = in_tag;
        acc_d   = '0;
        step_d  = '0;
        state_d = MUL;
`ifdef BYPASS_ZERO_EN
        if (in_a == '0 || in_b == '0) begin
          prod_d  = '0;
          otag_d  = in_tag;
          state_d = DONE;
        end
`endif
      end
      MUL: begin
        acc_d  = sum;
        step_d = step_q + 2'd1;
        if (step_q == 2'd3) begin
          prod_d  = sum;
          otag_d  = tag_q;
          state_d = DONE;
        end
      end
      DONE: state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      step_q  <= '0;
      acc_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      tag_q   <= '0;
      prod_q  <= '0;
      otag_q  <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      acc_q   <= acc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      tag_q   <= tag_d;
      prod_q  <= prod_d;
      otag_q  <= otag_d;
    end
  end
endmodule
